// File: rtl/uart_xmit.sv
// UART transmitter: serialises one byte per ready/valid transfer into an 8N1 frame,
// or 8E1 when the UART_XMIT_PARITY_EN macro is defined.
module uart_xmit #(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int unsigned SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] LAST_TICK =
    CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);

  if (SYMBOL_EDGE_TIME < 2) begin : g_bad_baud
    $error("uart_xmit: CLOCK_FREQ/BAUD_RATE must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_XMIT_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                         state;
  state_t                         state_next;
  logic [CLOCK_COUNTER_WIDTH-1:0] clock_counter;
  logic [2:0]                     bit_counter;
  logic [7:0]                     data;
  logic                           transfer_c;
  logic                           bit_done_c;
  logic                           line_c;

  assign transfer_c = data_in_valid && data_in_ready;
  assign bit_done_c = (clock_counter == LAST_TICK);

  // Next state plus the line level for the bit currently being sent.
  always_comb begin
    state_next = state;
    line_c     = 1'b1;
    case (state)
      IDLE: begin
        if (transfer_c) state_next = START;
      end
      START: begin
        line_c = 1'b0;
        if (bit_done_c) state_next = DATA;
      end
      DATA: begin
        line_c = data[bit_counter];
        if (bit_done_c && (bit_counter == 3'd7)) begin
`ifdef UART_XMIT_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_XMIT_PARITY_EN
      PARITY: begin
        line_c = ^data;
        if (bit_done_c) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_done_c) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Bit timing, byte capture and the registered line/ready outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clock_counter <= '0;
      bit_counter   <= '0;
      data          <= '0;
      serial_out    <= 1'b1;
      data_in_ready <= 1'b0;
    end else begin
      if ((state == IDLE) || bit_done_c) clock_counter <= '0;
      else                               clock_counter <= clock_counter + 1'b1;

      if (state != DATA)   bit_counter <= '0;
      else if (bit_done_c) bit_counter <= bit_counter + 3'd1;

      if (transfer_c) data <= data_in;

      // line_c follows the current state, so the start bit appears one edge after the transfer
      serial_out    <= line_c;
      data_in_ready <= (state_next == IDLE);
    end
  end

endmodule

// File: tb/tb_uart_xmit.sv
// Self-checking bench for uart_xmit: a queue-based line model, a sampling receiver and
// literal frame checks; the parity build is selected by UART_XMIT_PARITY_EN.
module tb_uart_xmit;

  localparam int unsigned CLOCK_FREQ = 1000;
  localparam int unsigned BAUD_RATE  = 100;
  localparam int S = 10;
`ifdef UART_XMIT_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FB        = PAR ? 11 : 10;
  localparam int FRAME_CYC = FB * S;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       serial_out;

  int n_checks = 0;
  int n_fail   = 0;

  uart_xmit #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .serial_out    (serial_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted byte becomes a per-cycle queue of line levels.
  logic       exp_line  = 1'b1;
  logic       exp_ready = 1'b0;
  bit         sched[$];
  logic [7:0] rx_exp[$];
  bit         m_xfer;
  bit         m_bit;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sched.delete();
      rx_exp.delete();
      exp_line  = 1'b1;
      exp_ready = 1'b0;
    end else begin
      m_xfer   = data_in_valid && exp_ready;
      exp_line = (sched.size() > 0) ? sched.pop_front() : 1'b1;
      if (m_xfer) begin
        for (int j = 0; j < FB; j++) begin
          if (j == 0)                m_bit = 1'b0;
          else if (j <= 8)           m_bit = data_in[3'(j - 1)];
          else if (PAR && (j == 9))  m_bit = ^data_in;
          else                       m_bit = 1'b1;
          for (int k = 0; k < S; k++) sched.push_back(m_bit);
        end
        rx_exp.push_back(data_in);
      end
      exp_ready = (sched.size() == 0);
    end
  end

  // Compare DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    check("serial_out", 32'(serial_out), 32'(exp_line));
    check("data_in_ready", 32'(data_in_ready), 32'(exp_ready));
  end

  // Mid-bit sampling receiver, independent of the model's queue.
  bit         rx_busy = 1'b0;
  int         rx_cnt  = 0;
  int         rx_j;
  logic [7:0] rx_sh;
  logic       rx_par;

  always @(negedge clk) begin
    if (!reset) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (serial_out == 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if ((rx_cnt % S) == (S / 2)) begin
        rx_j = rx_cnt / S;
        if ((rx_j >= 1) && (rx_j <= 8)) begin
          rx_sh[3'(rx_j - 1)] = serial_out;
        end else if (PAR && (rx_j == 9)) begin
          rx_par = serial_out;
        end else if (rx_j == FB - 1) begin
          check("rx_stop_bit", 32'(serial_out), 32'd1);
          if (PAR) check("rx_parity", 32'(rx_par), 32'(^rx_sh));
          if (rx_exp.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_unexpected_frame: got byte %0h expected no frame", rx_sh);
          end else begin
            check("rx_byte", 32'(rx_sh), 32'(rx_exp.pop_front()));
          end
          rx_busy = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input string name);
    int guard;
    guard = 0;
    while ((data_in_ready !== 1'b1) && (guard < 4 * FRAME_CYC)) begin
      tick();
      guard++;
    end
    if (guard >= 4 * FRAME_CYC) check(name, 32'(data_in_ready), 32'd1);
  endtask

  // Sends one byte and samples every frame bit at mid-bit; counts cycles with ready low.
  task automatic send_frame(input logic [7:0] b, output logic [10:0] bits, output int low);
    wait_ready("send_wait_ready");
    data_in       = b;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    data_in       = 8'($urandom);
    bits          = '1;
    low           = 0;
    for (int c = 0; c < FRAME_CYC + 4; c++) begin
      if (data_in_ready == 1'b0) low++;
      if ((c >= 1) && (((c - 1) % S) == (S / 2)) && (((c - 1) / S) < FB))
        bits[4'((c - 1) / S)] = serial_out;
      tick();
    end
  endtask

  logic [10:0] bits;
  int          low;
  int          falls;
  int          first_fall;
  int          gap;
  int          zeros;
  logic        prev;

  initial begin
    reset         = 1'b1;
    data_in_valid = 1'b0;
    data_in       = 8'h00;
    #1;
    // Reset held with valid asserted: no frame, ready low.
    reset         = 1'b0;
    data_in_valid = 1'b1;
    data_in       = 8'h3C;
    repeat (6) tick();
    check("reset_line", 32'(serial_out), 32'd1);
    check("reset_ready", 32'(data_in_ready), 32'd0);
    data_in_valid = 1'b0;
    reset         = 1'b1;
    #1;
    check("ready_at_release", 32'(data_in_ready), 32'd0);
    tick();
    check("ready_after_release", 32'(data_in_ready), 32'd1);

    // Single byte A5 with literal bit and handshake timing.
    send_frame(8'hA5, bits, low);
    check("a5_start", 32'(bits[0]), 32'd0);
    check("a5_data", 32'(bits[8:1]), 32'hA5);
    check("a5_stop", 32'(bits[4'(FB - 1)]), 32'd1);
`ifdef UART_XMIT_PARITY_EN
    check("a5_parity", 32'(bits[9]), 32'd0);
    check("a5_ready_low", 32'(low), 32'd110);
`else
    check("a5_ready_low", 32'(low), 32'd100);
`endif

    // Back-to-back 00 then FF with valid held high.
    wait_ready("b2b_wait_ready");
    data_in       = 8'h00;
    data_in_valid = 1'b1;
    tick();
    data_in    = 8'hFF;
    falls      = 0;
    first_fall = -1;
    gap        = -1;
    prev       = 1'b1;
    for (int c = 0; (c < 3 * FRAME_CYC) && (falls < 2); c++) begin
      if ((prev == 1'b1) && (serial_out == 1'b0)) begin
        if (falls == 0) first_fall = c;
        else            gap = c - first_fall;
        falls++;
      end
      prev = serial_out;
      tick();
    end
    data_in_valid = 1'b0;
    check("b2b_start_to_start", 32'(gap), 32'(FRAME_CYC + 1));
    repeat (FRAME_CYC + 5) tick();

    // Valid held while busy with data changing every cycle.
    wait_ready("busy_wait_ready");
    data_in_valid = 1'b1;
    for (int c = 0; c < 3 * FRAME_CYC + 10; c++) begin
      data_in = 8'($urandom);
      tick();
    end
    data_in_valid = 1'b0;
    repeat (FRAME_CYC + 5) tick();

    // Reset pulsed during data bit 3 (frame cycle 45) of an all-zero byte.
    wait_ready("abort_wait_ready");
    data_in       = 8'h00;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    repeat (46) tick();
    check("abort_line_before", 32'(serial_out), 32'd0);
    #1;
    reset = 1'b0;
    #1;
    check("abort_line_async", 32'(serial_out), 32'd1);
    check("abort_ready_async", 32'(data_in_ready), 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    zeros = 0;
    for (int c = 0; c < 2 * FRAME_CYC; c++) begin
      if (serial_out == 1'b0) zeros++;
      tick();
    end
    check("abort_no_resume", 32'(zeros), 32'd0);

    // Parity-bit placement for 01 and 03 (stop bit in the 8N1 build).
    send_frame(8'h01, bits, low);
    check("b01_data", 32'(bits[8:1]), 32'h01);
`ifdef UART_XMIT_PARITY_EN
    check("b01_parity", 32'(bits[9]), 32'd1);
    check("b01_stop", 32'(bits[10]), 32'd1);
`else
    check("b01_stop", 32'(bits[9]), 32'd1);
`endif
    send_frame(8'h03, bits, low);
    check("b03_data", 32'(bits[8:1]), 32'h03);
`ifdef UART_XMIT_PARITY_EN
    check("b03_parity", 32'(bits[9]), 32'd0);
    check("b03_stop", 32'(bits[10]), 32'd1);
`else
    check("b03_stop", 32'(bits[9]), 32'd1);
`endif

    // Random valid/data traffic.
    for (int c = 0; c < 2000; c++) begin
      data_in_valid = ($urandom_range(0, 3) == 0);
      data_in       = 8'($urandom);
      tick();
    end
    data_in_valid = 1'b0;
    repeat (2 * FRAME_CYC + 5) tick();
    check("rx_all_decoded", 32'(rx_exp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
